// File: rtl/hub75_fb_readout_mb.sv
// HUB75 row preloader: fetches one panel row from the frame buffer through
// the arbiter, extracts bit-planes and queues the row in a ring of line slots.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rd_row_addr/mirror/load          row preload request (row, h-mirror, pulse)
//   rd_row_busy, rd_row_rdy          load would be ignored / completed row queued
//   rd_row_swap                      advance the displayed slot
//   rd_col_addr, rd_en, rd_data      scan-out read port (1-cycle latency)
//   ctrl_req, ctrl_gnt, ctrl_rel     arbiter handshake
//   fb_addr, fb_rden, fb_data        frame-buffer read port ({row,col,bank,dc})
module hub75_fb_readout_mb #(
    parameter int N_BANKS   = 2,
    parameter int N_ROWS    = 32,
    parameter int N_COLS    = 64,
    parameter int N_CHANS   = 3,
    parameter int N_PLANES  = 8,
    parameter int BITDEPTH  = 24,
    parameter int FB_AW     = 13,
    parameter int FB_DW     = 16,
    parameter int FB_DC     = 2,
    parameter int N_LB_BUFS = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [$clog2(N_ROWS)-1:0]           rd_row_addr,
    input  logic                                rd_row_mirror,
    input  logic                                rd_row_load,
    output logic                                rd_row_busy,
    output logic                                rd_row_rdy,
    input  logic                                rd_row_swap,
    input  logic [$clog2(N_COLS)-1:0]           rd_col_addr,
    input  logic                                rd_en,
    output logic [N_BANKS*N_CHANS*N_PLANES-1:0] rd_data,
    output logic                                ctrl_req,
    input  logic                                ctrl_gnt,
    output logic                                ctrl_rel,
    output logic [FB_AW-1:0]                    fb_addr,
    output logic                                fb_rden,
    input  logic [FB_DW-1:0]                    fb_data
);

    localparam int LOG_N_ROWS = $clog2(N_ROWS);
    localparam int LOG_N_COLS = $clog2(N_COLS);
    localparam int CW   = FB_AW - LOG_N_ROWS;
    localparam int N_RD = N_COLS * N_BANKS * FB_DC;
    localparam int PW   = N_CHANS * N_PLANES;
    localparam int BPC  = BITDEPTH / N_CHANS;
    localparam int PTRW = $clog2(N_LB_BUFS);
    localparam int LBW  = PTRW + LOG_N_COLS;
    localparam int PIXW = FB_DC * FB_DW;
    localparam int BW   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                  r_state;
    logic [LOG_N_ROWS-1:0]   r_row;
    logic                    r_mirror;
    logic                    r_fb_rden;
    logic [FB_AW-1:0]        r_fb_addr;
    logic                    r_rel;
    logic [PTRW-1:0]         r_fill;
    logic [PTRW-1:0]         r_wr_ptr;
    logic [PTRW-1:0]         r_disp_ptr;

    logic                    r_p1_v;
    logic                    r_p1_last;
    logic [CW-1:0]           r_p1_cnt;
    logic [PIXW-1:0]         r_pix;
    logic                    r_wr_v;
    logic                    r_wr_last;
    logic [LOG_N_COLS-1:0]   r_wr_col;
    logic [BW-1:0]           r_wr_bank;
    logic [PW-1:0]           r_wr_planes;

    logic [PW-1:0]           r_lb [N_BANKS][2**LBW];
    logic [N_BANKS*PW-1:0]   r_rd_data;

    logic                    w_busy;
    logic                    w_load;
    logic                    w_swap;
    logic                    w_done;
    logic                    w_last_cnt;
    int                      w_dc;
    logic                    w_dc_last;
    logic [BW-1:0]           w_bank;
    logic [LOG_N_COLS-1:0]   w_col;
    logic [PIXW-1:0]         w_pix;
    logic [PW-1:0]           w_planes;

    function automatic logic [PTRW-1:0] f_next(input logic [PTRW-1:0] p);
        return (p == PTRW'(N_LB_BUFS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Busy is judged on pre-swap fill, so a same-cycle swap cannot admit a load.
    assign w_busy     = (r_state != S_IDLE) || (r_fill == PTRW'(N_LB_BUFS - 1));
    assign w_load     = rd_row_load && !w_busy;
    assign w_swap     = rd_row_swap && (r_fill != '0);
    assign w_done     = (r_state == S_FLUSH) && r_rel;
    assign w_last_cnt = (r_fb_addr[CW-1:0] == CW'(N_RD - 1));

    // Decode the read that returned this cycle and fold its word into the pixel.
    always_comb begin
        w_dc      = int'(r_p1_cnt) % FB_DC;
        w_dc_last = (w_dc == FB_DC - 1);
        w_bank    = BW'((int'(r_p1_cnt) / FB_DC) % N_BANKS);
        w_col     = LOG_N_COLS'(int'(r_p1_cnt) / (FB_DC * N_BANKS));
        if (r_mirror) begin
            w_col = ~w_col;
        end
        w_pix = r_pix;
        w_pix[w_dc*FB_DW +: FB_DW] = fb_data;
        w_planes = '0;
        for (int c = 0; c < N_CHANS; c++) begin
            w_planes[c*N_PLANES +: N_PLANES] =
                w_pix[c*BPC + BPC - N_PLANES +: N_PLANES];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_mirror   <= 1'b0;
            r_fb_rden  <= 1'b0;
            r_fb_addr  <= '0;
            r_rel      <= 1'b0;
            r_fill     <= '0;
            r_wr_ptr   <= PTRW'(1);
            r_disp_ptr <= '0;
        end else begin
            r_rel <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_row    <= rd_row_addr;
                        r_mirror <= rd_row_mirror;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ctrl_gnt) begin
                        r_state   <= S_RUN;
                        r_fb_rden <= 1'b1;
                        r_fb_addr <= {r_row, CW'(0)};
                    end
                end
                S_RUN: begin
                    if (w_last_cnt) begin
                        r_state   <= S_FLUSH;
                        r_fb_rden <= 1'b0;
                    end else begin
                        r_fb_addr <= r_fb_addr + 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Release one cycle after the final line-buffer write.
                    if (r_rel) begin
                        r_state  <= S_IDLE;
                        r_wr_ptr <= f_next(r_wr_ptr);
                    end else if (r_wr_v && r_wr_last) begin
                        r_rel <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_done && !w_swap) begin
                r_fill <= r_fill + 1'b1;
            end else if (!w_done && w_swap) begin
                r_fill <= r_fill - 1'b1;
            end
            if (w_swap) begin
                r_disp_ptr <= f_next(r_disp_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_v    <= 1'b0;
            r_p1_last <= 1'b0;
            r_wr_v    <= 1'b0;
            r_wr_last <= 1'b0;
        end else begin
            r_p1_v    <= r_fb_rden;
            r_p1_last <= r_fb_rden && w_last_cnt;
            r_wr_v    <= r_p1_v && w_dc_last;
            r_wr_last <= r_p1_v && r_p1_last;
        end
        r_p1_cnt <= r_fb_addr[CW-1:0];
        if (r_p1_v) begin
            r_pix <= w_pix;
        end
        r_wr_col    <= w_col;
        r_wr_bank   <= w_bank;
        r_wr_planes <= w_planes;
    end

    always_ff @(posedge clk) begin
        if (r_wr_v) begin
            r_lb[r_wr_bank][{r_wr_ptr, r_wr_col}] <= r_wr_planes;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            for (int b = 0; b < N_BANKS; b++) begin
                r_rd_data[b*PW +: PW] <= r_lb[b][{r_disp_ptr, rd_col_addr}];
            end
        end
    end

    assign rd_row_busy = w_busy;
    assign rd_row_rdy  = (r_fill != '0);
    assign ctrl_req    = (r_state == S_REQ);
    assign ctrl_rel    = r_rel;
    assign fb_addr     = r_fb_addr;
    assign fb_rden     = r_fb_rden;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_hub75_fb_readout_mb.sv
// Scoreboard bench for hub75_fb_readout_mb: default build plus an FB_DC=1 build.
// Expected reads and scan-out words are queued at stimulus time.
module tb_hub75_fb_readout_mb;

    localparam int NP  = 8;
    localparam int BPC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_row_addr = '0;
    logic        rd_row_mirror = 1'b0;
    logic        rd_row_load = 1'b0;
    logic        rd_row_swap = 1'b0;
    logic [5:0]  rd_col_addr = '0;
    logic        rd_en = 1'b0;
    logic        ctrl_gnt = 1'b0;
    logic [15:0] fb_data = '0;
    logic        rd_row_busy, rd_row_rdy, ctrl_req, ctrl_rel, fb_rden;
    logic [47:0] rd_data;
    logic [12:0] fb_addr;

    logic        b_load = 1'b0;
    logic        b_swap = 1'b0;
    logic [4:0]  b_row = '0;
    logic [5:0]  b_col = '0;
    logic        b_en = 1'b0;
    logic        b_gnt = 1'b0;
    logic [23:0] b_fb_data = '0;
    logic        b_busy, b_rdy, b_req, b_rel, b_fb_rden;
    logic [47:0] b_rd_data;
    logic [11:0] b_fb_addr;

    always #5 clk = ~clk;

    hub75_fb_readout_mb dut (
        .clk(clk), .rst(rst),
        .rd_row_addr(rd_row_addr), .rd_row_mirror(rd_row_mirror),
        .rd_row_load(rd_row_load), .rd_row_busy(rd_row_busy),
        .rd_row_rdy(rd_row_rdy), .rd_row_swap(rd_row_swap),
        .rd_col_addr(rd_col_addr), .rd_en(rd_en), .rd_data(rd_data),
        .ctrl_req(ctrl_req), .ctrl_gnt(ctrl_gnt), .ctrl_rel(ctrl_rel),
        .fb_addr(fb_addr), .fb_rden(fb_rden), .fb_data(fb_data)
    );

    hub75_fb_readout_mb #(.FB_DC(1), .FB_DW(24), .FB_AW(12)) dut1 (
        .clk(clk), .rst(rst),
        .rd_row_addr(b_row), .rd_row_mirror(1'b0),
        .rd_row_load(b_load), .rd_row_busy(b_busy),
        .rd_row_rdy(b_rdy), .rd_row_swap(b_swap),
        .rd_col_addr(b_col), .rd_en(b_en), .rd_data(b_rd_data),
        .ctrl_req(b_req), .ctrl_gnt(b_gnt), .ctrl_rel(b_rel),
        .fb_addr(b_fb_addr), .fb_rden(b_fb_rden), .fb_data(b_fb_data)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a row is described by what was fetched, and pixels are
    // recomputed from the frame-buffer pattern whenever they are needed.
    typedef struct packed {
        logic [4:0]  row;
        logic        mir;
        logic [15:0] key;
    } desc_t;

    desc_t       pend_q[$];
    desc_t       disp;
    logic [15:0] key = '0;
    logic [23:0] key1 = '0;

    function automatic logic [23:0] planes(logic [23:0] pix);
        logic [23:0] r = '0;
        for (int c = 0; c < 3; c++) begin
            r[c*NP +: NP] = pix[c*BPC + BPC - NP +: NP];
        end
        return r;
    endfunction

    function automatic logic [47:0] exp_rd(desc_t d, logic [5:0] col);
        logic [47:0] r = '0;
        logic [5:0]  src = d.mir ? 6'd63 - col : col;
        for (int b = 0; b < 2; b++) begin
            logic [12:0] a = {d.row, src, b[0], 1'b0};
            logic [15:0] w0 = {3'b0, a} ^ d.key;
            logic [15:0] w1 = {3'b0, a | 13'd1} ^ d.key;
            logic [31:0] pix = {w1, w0};
            r[b*24 +: 24] = planes(pix[23:0]);
        end
        return r;
    endfunction

    function automatic logic [47:0] exp_rd1(logic [4:0] row, logic [5:0] col);
        logic [47:0] r = '0;
        for (int b = 0; b < 2; b++) begin
            logic [11:0] a = {row, col, b[0]};
            r[b*24 +: 24] = planes({a, a} ^ key1);
        end
        return r;
    endfunction

    // Frame-buffer models: one-cycle read latency.
    always @(posedge clk) begin
        fb_data   <= fb_rden ? ({3'b0, fb_addr} ^ key) : 16'h0;
        b_fb_data <= b_fb_rden ? ({b_fb_addr, b_fb_addr} ^ key1) : 24'h0;
    end

    logic [12:0] addr_q[$];
    logic [11:0] addr1_q[$];
    logic [47:0] rd_q[$];
    logic [47:0] rd1_q[$];
    int          rd_cnt = 0;
    int          rd1_cnt = 0;
    logic        rd_pend = 1'b0;
    logic        rd1_pend = 1'b0;

    always @(posedge clk) begin
        rd_pend  <= rd_en && !rst;
        rd1_pend <= b_en && !rst;
    end

    always @(negedge clk) begin
        if (!rst && fb_rden) begin
            rd_cnt++;
            if (addr_q.size() == 0) check("fb_addr_unexpected", fb_addr, '0 - 1);
            else check("fb_addr", fb_addr, addr_q.pop_front());
        end
        if (!rst && b_fb_rden) begin
            rd1_cnt++;
            if (addr1_q.size() == 0) check("fb_addr1_unexpected", b_fb_addr, '0 - 1);
            else check("fb_addr1", b_fb_addr, addr1_q.pop_front());
        end
        if (rd_pend) begin
            if (rd_q.size() == 0) check("rd_data_unexpected", rd_data, '0 - 1);
            else check("rd_data", rd_data, rd_q.pop_front());
        end
        if (rd1_pend) begin
            if (rd1_q.size() == 0) check("rd_data1_unexpected", b_rd_data, '0 - 1);
            else check("rd_data1", b_rd_data, rd1_q.pop_front());
        end
    end

    task automatic rd(logic [5:0] col);
        rd_col_addr = col;
        rd_en = 1'b1;
        rd_q.push_back(exp_rd(disp, col));
        tick();
        rd_en = 1'b0;
    endtask

    task automatic rd_some();
        rd(6'd0);
        rd(6'd63);
        repeat (4) rd(6'($urandom_range(0, 63)));
    endtask

    task automatic swap();
        rd_row_swap = 1'b1;
        tick();
        rd_row_swap = 1'b0;
        if (pend_q.size() != 0) disp = pend_q.pop_front();
    endtask

    task automatic fetch(logic [4:0] row, logic mir, int gdly, bit swap_rel);
        int  n;
        bit  had;
        rd_row_addr = row;
        rd_row_mirror = mir;
        rd_row_load = 1'b1;
        tick();
        rd_row_load = 1'b0;
        check("req_up", ctrl_req, 1);
        check("busy_fetch", rd_row_busy, 1);
        for (int a = 0; a < 256; a++) addr_q.push_back({row, a[7:0]});
        repeat (gdly) tick();
        ctrl_gnt = 1'b1;
        rd_cnt = 0;
        tick();
        ctrl_gnt = 1'b0;
        n = 1;
        while (!ctrl_rel && n < 2000) begin
            tick();
            n++;
        end
        check("gnt_to_rel", n, 259);
        check("read_count", rd_cnt, 256);
        had = pend_q.size() != 0;
        check("rdy_at_rel", rd_row_rdy, had);
        if (swap_rel) rd_row_swap = 1'b1;
        tick();
        rd_row_swap = 1'b0;
        pend_q.push_back('{row, mir, key});
        if (swap_rel && had) disp = pend_q.pop_front();
        check("rel_pulse", ctrl_rel, 0);
        check("rdy_after_rel", rd_row_rdy, 1);
        check("addr_q_drained", addr_q.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [47:0] held;
        logic [4:0]  r;

        repeat (3) tick();
        check("rst_busy", rd_row_busy, 0);
        check("rst_rdy", rd_row_rdy, 0);
        check("rst_req", ctrl_req, 0);
        check("rst_rel", ctrl_rel, 0);
        check("rst_rden", fb_rden, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();

        key = 16'h0;
        fetch(5'd5, 1'b0, 2, 0);
        swap();
        check("rdy_after_swap", rd_row_rdy, 0);
        rd_some();

        fetch(5'd5, 1'b1, $urandom_range(0, 4), 0);
        swap();
        rd_some();

        key = 16'($urandom);
        fetch(5'($urandom), 1'b0, $urandom_range(0, 3), 0);
        key = 16'($urandom);
        fetch(5'($urandom), 1'($urandom), $urandom_range(0, 3), 0);
        check("full_busy", rd_row_busy, 1);
        check("full_rdy", rd_row_rdy, 1);
        rd_row_addr = 5'd7;
        rd_row_load = 1'b1;
        tick();
        rd_row_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ignored_load_req", ctrl_req, 0);
            tick();
        end
        swap();
        check("busy_cleared", rd_row_busy, 0);
        rd_some();
        swap();
        rd_some();
        check("empty_rdy", rd_row_rdy, 0);

        // Swap with nothing queued keeps the display on the same slot.
        rd(6'd10);
        swap();
        rd(6'd10);
        held = exp_rd(disp, 6'd10);
        repeat (3) tick();
        check("rd_data_hold", rd_data, held);

        key = 16'($urandom);
        fetch(5'($urandom), 1'b0, 1, 0);
        key = 16'($urandom);
        fetch(5'($urandom), 1'b1, 0, 1);
        check("swap_and_done_rdy", rd_row_rdy, 1);
        check("swap_and_done_busy", rd_row_busy, 0);
        rd_some();
        swap();
        rd_some();
        check("final_empty", rd_row_rdy, 0);

        // Reset in the middle of a fetch.
        key = 16'($urandom);
        r = 5'($urandom);
        rd_row_addr = r;
        rd_row_load = 1'b1;
        tick();
        rd_row_load = 1'b0;
        for (int a = 0; a < 256; a++) addr_q.push_back({r, a[7:0]});
        ctrl_gnt = 1'b1;
        tick();
        ctrl_gnt = 1'b0;
        repeat (39) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_req", ctrl_req, 0);
        check("mid_rst_rden", fb_rden, 0);
        check("mid_rst_rel", ctrl_rel, 0);
        check("mid_rst_rdy", rd_row_rdy, 0);
        check("mid_rst_busy", rd_row_busy, 0);
        rst = 1'b0;
        addr_q.delete();
        pend_q.delete();
        n = 0;
        repeat (4) begin
            tick();
            if (ctrl_rel) n++;
        end
        check("no_rel_after_rst", n, 0);
        key = 16'($urandom);
        fetch(5'($urandom), 1'($urandom), 2, 0);
        swap();
        rd_some();

        // FB_DC=1 build: one word per pixel.
        key1 = 24'($urandom);
        r = 5'($urandom);
        b_row = r;
        b_load = 1'b1;
        tick();
        b_load = 1'b0;
        check("b_req_up", b_req, 1);
        for (int a = 0; a < 128; a++) addr1_q.push_back({r, a[6:0]});
        tick();
        b_gnt = 1'b1;
        rd1_cnt = 0;
        tick();
        b_gnt = 1'b0;
        n = 1;
        while (!b_rel && n < 2000) begin
            tick();
            n++;
        end
        check("b_gnt_to_rel", n, 131);
        check("b_read_count", rd1_cnt, 128);
        tick();
        check("b_rdy", b_rdy, 1);
        b_swap = 1'b1;
        tick();
        b_swap = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_col = (i == 0) ? 6'd0 : (i == 1) ? 6'd63 : 6'($urandom);
            b_en = 1'b1;
            rd1_q.push_back(exp_rd1(r, b_col));
            tick();
            b_en = 1'b0;
        end

        repeat (3) tick();
        check("rd_q_drained", rd_q.size(), 0);
        check("rd1_q_drained", rd1_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
